// File: rtl/axis_combiner_pkg.sv
// rtl/axis_combiner_pkg.sv - width helpers shared with the channel splitter
package axis_combiner_pkg;

  function automatic int keep_width_for(input int data_width, input bit keep_enable);
    return keep_enable ? (data_width + 7) / 8 : 1;
  endfunction

  function automatic int side_width_for(input bit enable);
    return enable ? 8 : 1;
  endfunction

endpackage

// File: rtl/axis_register.sv
// rtl/axis_register.sv - skid register stage: full throughput, registered upstream ready
module axis_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             advance;

  assign s_tready = ~skid_valid;
  assign advance  = m_tready | ~m_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (advance) begin
      m_tvalid   <= skid_valid | s_tvalid;
      skid_valid <= 1'b0;
    end else if (s_tvalid & s_tready) begin
      skid_valid <= 1'b1;
    end
  end

  // A beat accepted while the output is stalled parks in the skid slot.
  always_ff @(posedge clk) begin
    if (advance) begin
      m_tdata <= skid_valid ? skid_data : s_tdata;
    end else if (s_tvalid & s_tready) begin
      skid_data <= s_tdata;
    end
  end

endmodule

// File: rtl/axis_combiner.sv
// rtl/axis_combiner.sv - merges CHANNELS narrow streams into one wide stream, one slot per lane
module axis_combiner
  import axis_combiner_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 4,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = keep_width_for(DATA_WIDTH, KEEP_ENABLE),
  parameter bit LAST_ENABLE = 1'b1,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = side_width_for(ID_ENABLE),
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = side_width_for(DEST_ENABLE),
  parameter bit USER_ENABLE = 1'b0,
  parameter int USER_WIDTH  = side_width_for(USER_ENABLE),
  parameter bit EXTRA_CYCLE = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [CHANNELS*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic                           err_last_mismatch
);

  localparam int DW_ALL = CHANNELS * DATA_WIDTH;
  localparam int KW_ALL = CHANNELS * KEEP_WIDTH;
  localparam int PW     = DW_ALL + KW_ALL + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [CHANNELS-1:0]   slot_valid, slot_last, take;
  logic [DW_ALL-1:0]     slot_data;
  logic [KW_ALL-1:0]     slot_keep, keep_out;
  logic [ID_WIDTH-1:0]   slot_id, id_out;
  logic [DEST_WIDTH-1:0] slot_dest, dest_out;
  logic [USER_WIDTH-1:0] slot_user, user_out;
  logic                  last_out;
  logic                  comb_valid, comb_ready, fire;
  logic [PW-1:0]         comb_payload, out_payload;
  logic                  unused_inputs;

  assign comb_valid = &slot_valid;
  assign fire       = comb_valid & comb_ready;
  assign take       = s_axis_tvalid & s_axis_tready;

  // A slot may empty and refill on the same edge, so full lanes see ready while the wide beat fires.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign s_axis_tready[c] = ~slot_valid[c] | fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid        <= '0;
      err_last_mismatch <= 1'b0;
    end else begin
      slot_valid <= take | (slot_valid & ~{CHANNELS{fire}});
      if (LAST_ENABLE && fire && (|slot_last) && !(&slot_last)) begin
        err_last_mismatch <= 1'b1;
      end
    end
  end

  // Wide sidebands come from channel 0, so only its slot keeps them.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (take[c]) begin
        slot_data[c*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        slot_keep[c*KEEP_WIDTH +: KEEP_WIDTH] <= s_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
        slot_last[c]                          <= s_axis_tlast[c];
      end
    end
    if (take[0]) begin
      slot_id   <= s_axis_tid[ID_WIDTH-1:0];
      slot_dest <= s_axis_tdest[DEST_WIDTH-1:0];
      slot_user <= s_axis_tuser[USER_WIDTH-1:0];
    end
  end

  assign keep_out = KEEP_ENABLE ? slot_keep : '1;
  assign last_out = LAST_ENABLE ? slot_last[0] : 1'b0;
  assign id_out   = ID_ENABLE ? slot_id : '0;
  assign dest_out = DEST_ENABLE ? slot_dest : '0;
  assign user_out = USER_ENABLE ? slot_user : '0;

  assign comb_payload = {last_out, id_out, dest_out, user_out, keep_out, slot_data};

  if (EXTRA_CYCLE) begin : g_out_reg
    axis_register #(
      .WIDTH(PW)
    ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (comb_payload),
      .s_tvalid (comb_valid),
      .s_tready (comb_ready),
      .m_tdata  (out_payload),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready)
    );
  end else begin : g_out_direct
    assign out_payload   = comb_payload;
    assign m_axis_tvalid = comb_valid;
    assign comb_ready    = m_axis_tready;
  end

  assign {m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_payload;

  assign unused_inputs = ^{s_axis_tid, s_axis_tdest, s_axis_tuser};

endmodule
